egg_timer_datapath: RTL and testbench

//  Time-keeping datapath driven by the egg-timer controller's state bus. Loads minutes and

---
 rtl/egg_timer_pkg.sv | 52 +++++
 rtl/bcd_digit_pair.sv | 45 ++++
 rtl/egg_timer_datapath.sv | 140 ++++++++++++++
 tb/tb_egg_timer_datapath.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/egg_timer_pkg.sv
// egg_timer_pkg: controller state codes shared with the egg-timer controller,
// the internal decoded mode used by the datapath, and the BCD clamp helper.
package egg_timer_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned BCD_W   = 8;

    // Controller state codes (zero-extended to STATE_W bits on the bus)
    localparam logic [STATE_W-1:0] ST_SET_SEC     = 4'd0;
    localparam logic [STATE_W-1:0] ST_SET_MIN     = 4'd1;
    localparam logic [STATE_W-1:0] ST_TIMER       = 4'd2;
    localparam logic [STATE_W-1:0] ST_READY       = 4'd3;
    localparam logic [STATE_W-1:0] ST_RESET       = 4'd4;
    localparam logic [STATE_W-1:0] ST_FLASH_ON    = 4'd5;
    localparam logic [STATE_W-1:0] ST_FLASH_OFF   = 4'd6;
    localparam logic [STATE_W-1:0] ST_SETTING_MIN = 4'd7;

    // What the datapath does with each controller state
    typedef enum logic [2:0] {
        MODE_RESET,
        MODE_SET_SEC,
        MODE_SET_MIN,
        MODE_READY,
        MODE_TIMER,
        MODE_FLASH
    } mode_t;

    // Unlisted codes (including anything with state[3]=1) behave as RESET
    function automatic mode_t decode_state(input logic [STATE_W-1:0] s);
        mode_t m;
        case (s)
            ST_SET_SEC:                  m = MODE_SET_SEC;
            ST_SET_MIN, ST_SETTING_MIN:  m = MODE_SET_MIN;
            ST_READY:                    m = MODE_READY;
            ST_TIMER:                    m = MODE_TIMER;
            ST_FLASH_ON, ST_FLASH_OFF:   m = MODE_FLASH;
            default:                     m = MODE_RESET;
        endcase
        return m;
    endfunction

    // Saturate a tens:ones BCD switch value: ones to 9, tens to tens_max
    function automatic logic [BCD_W-1:0] clamp_bcd(input logic [BCD_W-1:0] v,
                                                   input logic [3:0]       tens_max);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = (v[7:4] > tens_max) ? tens_max : v[7:4];
        ones = (v[3:0] > 4'd9)     ? 4'd9     : v[3:0];
        return {tens, ones};
    endfunction

endpackage

// File: rtl/bcd_digit_pair.sv
// bcd_digit_pair: two-digit BCD register with synchronous clear, load and
// single-step decrement. The tens digit wraps 0 -> TENS_MAX on a borrow.
// Ports:
//   clk        system clock
//   clear      synchronous clear to 00 (highest priority)
//   load       load load_val
//   load_val   BCD tens:ones value to load (already clamped by the caller)
//   dec        borrow-in: decrement by one this cycle
//   value      registered BCD tens:ones
//   borrow_c   borrow-out: dec while the pair reads 00 (pair wraps)
//   is_zero_c  pair currently reads 00
module bcd_digit_pair #(
    parameter int unsigned TENS_MAX = 5
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       dec,
    output logic [7:0] value,
    output logic       borrow_c,
    output logic       is_zero_c
);

    always_comb begin
        is_zero_c = (value == 8'h00);
        borrow_c  = dec && is_zero_c;
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            value <= 8'h00;
        end else if (load) begin
            value <= load_val;
        end else if (dec) begin
            if (value[3:0] == 4'd0) begin
                value[3:0] <= 4'd9;
                value[7:4] <= (value[7:4] == 4'd0) ? 4'(TENS_MAX) : value[7:4] - 4'd1;
            end else begin
                value[3:0] <= value[3:0] - 4'd1;
            end
        end
    end

endmodule

// File: rtl/egg_timer_datapath.sv
// egg_timer_datapath: mm:ss time-keeping datapath for the egg timer. Loads
// minutes/seconds from switches in the set states, counts down in BCD in
// TIMER, raises a sticky done at 00:00 and blinks the display when flashing.
// Optional buzzer output when EGG_TIMER_BUZZER_EN is defined.
// Ports:
//   clk      system clock
//   reset    synchronous active-high reset
//   state    controller state code
//   sw       BCD set value, [7:4] tens, [3:0] ones
//   min_bcd  minutes, BCD
//   sec_bcd  seconds, BCD
//   done     sticky countdown-expired flag
//   blank    display blank request
//   buzzer   buzzer square wave (EGG_TIMER_BUZZER_EN only)
module egg_timer_datapath
    import egg_timer_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 50_000_000,
    parameter int unsigned FLASH_DIV = 25_000_000
`ifdef EGG_TIMER_BUZZER_EN
    ,
    parameter int unsigned BUZZ_DIV  = 25_000
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [STATE_W-1:0] state,
    input  logic [BCD_W-1:0]   sw,
    output logic [BCD_W-1:0]   min_bcd,
    output logic [BCD_W-1:0]   sec_bcd,
    output logic               done,
    output logic               blank
`ifdef EGG_TIMER_BUZZER_EN
    ,
    output logic               buzzer
`endif
);

    localparam int unsigned PRE_W = $clog2(TICK_DIV);
    localparam int unsigned BLK_W = $clog2(FLASH_DIV);

    mode_t            mode;
    logic [PRE_W-1:0] presc;
    logic [BLK_W-1:0] blink_cnt;
    logic             clear_c;
    logic             tick_c;
    logic             all_zero_c;
    logic             sec_dec_c;
    logic             lands_c;
    logic             sec_borrow;
    logic             sec_zero;
    logic             min_borrow;
    logic             min_zero;

    // Decode and countdown control
    always_comb begin
        mode       = decode_state(state);
        clear_c    = reset || (mode == MODE_RESET);
        tick_c     = (mode == MODE_TIMER) && (presc == PRE_W'(TICK_DIV - 1));
        all_zero_c = sec_zero && min_zero;
        sec_dec_c  = tick_c && !all_zero_c;
        lands_c    = sec_dec_c && min_zero && (sec_bcd == 8'h01);
    end

    bcd_digit_pair #(.TENS_MAX(5)) u_sec (
        .clk       (clk),
        .clear     (clear_c),
        .load      (mode == MODE_SET_SEC),
        .load_val  (clamp_bcd(sw, 4'd5)),
        .dec       (sec_dec_c),
        .value     (sec_bcd),
        .borrow_c  (sec_borrow),
        .is_zero_c (sec_zero)
    );

    bcd_digit_pair #(.TENS_MAX(9)) u_min (
        .clk       (clk),
        .clear     (clear_c),
        .load      (mode == MODE_SET_MIN),
        .load_val  (clamp_bcd(sw, 4'd9)),
        .dec       (sec_borrow),
        .value     (min_bcd),
        .borrow_c  (min_borrow),
        .is_zero_c (min_zero)
    );

    // Prescaler, done flag and blink generator
    always_ff @(posedge clk) begin
        if (clear_c) begin
            presc     <= '0;
            blink_cnt <= '0;
            done      <= 1'b0;
            blank     <= 1'b0;
        end else begin
            case (mode)
                MODE_READY: presc <= '0;
                MODE_TIMER: begin
                    presc <= tick_c ? '0 : presc + PRE_W'(1);
                    // A minute borrow-out would mean an underflow attempt: also expiry
                    if (all_zero_c || lands_c || min_borrow) begin
                        done <= 1'b1;
                    end
                end
                MODE_FLASH: begin
                    done <= 1'b1;
                    if (blink_cnt == BLK_W'(FLASH_DIV - 1)) begin
                        blink_cnt <= '0;
                        blank     <= ~blank;
                    end else begin
                        blink_cnt <= blink_cnt + BLK_W'(1);
                    end
                end
                default: ;
            endcase
            if (mode != MODE_FLASH) begin
                blank <= 1'b0;
            end
        end
    end

`ifdef EGG_TIMER_BUZZER_EN
    localparam int unsigned BZ_W = $clog2(BUZZ_DIV);

    logic [BZ_W-1:0] buzz_cnt;

    // Buzzer sounds only during the visible half of the flash
    always_ff @(posedge clk) begin
        if (clear_c || (mode != MODE_FLASH) || blank) begin
            buzz_cnt <= '0;
            buzzer   <= 1'b0;
        end else if (buzz_cnt == BZ_W'(BUZZ_DIV - 1)) begin
            buzz_cnt <= '0;
            buzzer   <= ~buzzer;
        end else begin
            buzz_cnt <= buzz_cnt + BZ_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_egg_timer_datapath.sv
// tb_egg_timer_datapath: directed bench for egg_timer_datapath with
// TICK_DIV=4, FLASH_DIV=3, BUZZ_DIV=2.
module tb_egg_timer_datapath;
    import egg_timer_pkg::*;

    logic       clk;
    logic       reset;
    logic [3:0] state;
    logic [7:0] sw;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic       done;
    logic       blank;
`ifdef EGG_TIMER_BUZZER_EN
    logic       buzzer;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    egg_timer_datapath #(
        .TICK_DIV  (4),
        .FLASH_DIV (3)
`ifdef EGG_TIMER_BUZZER_EN
        ,
        .BUZZ_DIV  (2)
`endif
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .state   (state),
        .sw      (sw),
        .min_bcd (min_bcd),
        .sec_bcd (sec_bcd),
        .done    (done),
        .blank   (blank)
`ifdef EGG_TIMER_BUZZER_EN
        ,
        .buzzer  (buzzer)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n clock edges, then settle 1 time unit past the edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] mm, input logic [7:0] ss);
        state = ST_SET_SEC; sw = ss; step(1);
        state = ST_SET_MIN; sw = mm; step(1);
    endtask

    task automatic test_reset;
        reset = 1'b1; state = ST_TIMER; sw = 8'h00;
        step(2);
        n_tests++; if (min_bcd !== 8'h00) begin n_fail++; $display("FAIL reset_min: got %h want 00", min_bcd); end
        n_tests++; if (sec_bcd !== 8'h00) begin n_fail++; $display("FAIL reset_sec: got %h want 00", sec_bcd); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_tests++; if (blank !== 1'b0) begin n_fail++; $display("FAIL reset_blank: got %b want 0", blank); end
        reset = 1'b0; state = ST_RESET; step(1);
    endtask

    task automatic test_clamp;
        state = ST_SET_SEC; sw = 8'h7C; step(1);
        n_tests++; if (sec_bcd !== 8'h59) begin n_fail++; $display("FAIL clamp_sec: got %h want 59", sec_bcd); end
        state = ST_SET_MIN; sw = 8'hA3; step(1);
        n_tests++; if (min_bcd !== 8'h93) begin n_fail++; $display("FAIL clamp_min: got %h want 93", min_bcd); end
        n_tests++; if (sec_bcd !== 8'h59) begin n_fail++; $display("FAIL clamp_sec_held: got %h want 59", sec_bcd); end
        state = ST_SETTING_MIN; sw = 8'h47; step(1);
        n_tests++; if (min_bcd !== 8'h47) begin n_fail++; $display("FAIL setting_min: got %h want 47", min_bcd); end
    endtask

    task automatic test_reset_mid;
        state = ST_RESET; step(1);
        load(8'h12, 8'h34);
        state = ST_READY; step(1);
        state = ST_TIMER; step(6);
        n_tests++; if (sec_bcd !== 8'h33) begin n_fail++; $display("FAIL mid_tick: got %h want 33", sec_bcd); end
        reset = 1'b1; step(1);
        n_tests++; if ({min_bcd, sec_bcd} !== 16'h0000) begin n_fail++; $display("FAIL mid_reset_mmss: got %h want 0000", {min_bcd, sec_bcd}); end
        n_tests++; if ({done, blank} !== 2'b00) begin n_fail++; $display("FAIL mid_reset_flags: got %b want 00", {done, blank}); end
        reset = 1'b0; state = ST_RESET; step(1);
    endtask

    task automatic test_countdown;
        state = ST_RESET; step(1);
        load(8'h01, 8'h00);
        state = ST_READY; step(1);
        state = ST_TIMER; step(3);
        n_tests++; if ({min_bcd, sec_bcd} !== 16'h0100) begin n_fail++; $display("FAIL cd_pre_tick: got %h want 0100", {min_bcd, sec_bcd}); end
        step(1);
        n_tests++; if ({min_bcd, sec_bcd} !== 16'h0059) begin n_fail++; $display("FAIL cd_first_tick: got %h want 0059", {min_bcd, sec_bcd}); end
        step(36);
        n_tests++; if ({min_bcd, sec_bcd} !== 16'h0050) begin n_fail++; $display("FAIL cd_0050: got %h want 0050", {min_bcd, sec_bcd}); end
        step(4);
        n_tests++; if ({min_bcd, sec_bcd} !== 16'h0049) begin n_fail++; $display("FAIL cd_tens_borrow: got %h want 0049", {min_bcd, sec_bcd}); end
        step(192);
        n_tests++; if ({min_bcd, sec_bcd} !== 16'h0001) begin n_fail++; $display("FAIL cd_0001: got %h want 0001", {min_bcd, sec_bcd}); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL cd_done_early: got %b want 0", done); end
        step(3);
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL cd_done_before_tick: got %b want 0", done); end
        step(1);
        n_tests++; if ({min_bcd, sec_bcd} !== 16'h0000) begin n_fail++; $display("FAIL cd_zero: got %h want 0000", {min_bcd, sec_bcd}); end
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL cd_done_same_cycle: got %b want 1", done); end
        step(8);
        n_tests++; if ({min_bcd, sec_bcd} !== 16'h0000) begin n_fail++; $display("FAIL cd_no_wrap: got %h want 0000", {min_bcd, sec_bcd}); end
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL cd_done_sticky: got %b want 1", done); end
    endtask

    task automatic test_min_borrow;
        state = ST_RESET; step(1);
        load(8'h10, 8'h00);
        state = ST_READY; step(1);
        state = ST_TIMER; step(4);
        n_tests++; if ({min_bcd, sec_bcd} !== 16'h0959) begin n_fail++; $display("FAIL min_tens_borrow: got %h want 0959", {min_bcd, sec_bcd}); end
    endtask

    task automatic test_zero_entry;
        state = ST_RESET; step(1);
        load(8'h00, 8'h00);
        state = ST_READY; step(1);
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL ze_ready_done: got %b want 0", done); end
        state = ST_TIMER; step(1);
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL ze_done: got %b want 1", done); end
        step(6);
        n_tests++; if ({min_bcd, sec_bcd} !== 16'h0000) begin n_fail++; $display("FAIL ze_mmss: got %h want 0000", {min_bcd, sec_bcd}); end
    endtask

    task automatic test_flash;
        logic exp_blank;
        state = ST_RESET; step(1);
        load(8'h02, 8'h30);
        state = ST_FLASH_ON;
        for (int k = 1; k <= 9; k++) begin
            step(1);
            exp_blank = ((k / 3) % 2) == 1;
            n_tests++; if (blank !== exp_blank) begin n_fail++; $display("FAIL flash_blank_%0d: got %b want %b", k, blank, exp_blank); end
        end
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL flash_done: got %b want 1", done); end
        n_tests++; if ({min_bcd, sec_bcd} !== 16'h0230) begin n_fail++; $display("FAIL flash_mmss: got %h want 0230", {min_bcd, sec_bcd}); end
        state = ST_READY; step(1);
        n_tests++; if (blank !== 1'b0) begin n_fail++; $display("FAIL flash_leave_blank: got %b want 0", blank); end
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL flash_leave_done: got %b want 1", done); end
        state = ST_RESET; step(1);
        n_tests++; if ({done, blank} !== 2'b00) begin n_fail++; $display("FAIL flash_reset: got %b want 00", {done, blank}); end
    endtask

    task automatic test_unknown;
        state = ST_RESET; step(1);
        load(8'h05, 8'h05);
        state = 4'hF; step(2);
        n_tests++; if ({min_bcd, sec_bcd} !== 16'h0000) begin n_fail++; $display("FAIL unk_F_mmss: got %h want 0000", {min_bcd, sec_bcd}); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL unk_F_done: got %b want 0", done); end
        load(8'h05, 8'h05);
        state = 4'h8; step(1);
        n_tests++; if ({min_bcd, sec_bcd} !== 16'h0000) begin n_fail++; $display("FAIL unk_8_mmss: got %h want 0000", {min_bcd, sec_bcd}); end
    endtask

    initial begin
        reset = 1'b1;
        state = ST_RESET;
        sw    = 8'h00;
        test_reset();
        test_clamp();
        test_reset_mid();
        test_countdown();
        test_min_borrow();
        test_zero_entry();
        test_flash();
        test_unknown();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
